// File: rtl/sobel_rgb_green_outline_sdiv_21s_11s_seq.sv
// Purpose: sequential signed divider (21s / 11s), C semantics (quotient truncates toward zero, remainder takes dividend sign).
// Latency: out_valid rises din0_WIDTH+1 edges after accept (22 by default); divide-by-zero takes 1 edge.
// Backpressure: one division in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Optional feature: define SOBEL_SDIV_DBZ_FLAG_EN to add the registered dbz output.
module sobel_rgb_green_outline_sdiv_21s_11s_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 21,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 21
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef SOBEL_SDIV_DBZ_FLAG_EN
  output logic                  dbz,
`endif
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem
);

  // ID is an instance tag only; it is folded in at zero weight so it stays a real parameter.
  localparam int CNT_W = $clog2(din0_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(din0_WIDTH - 1 + 0 * ID);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [din0_WIDTH-1:0] dq;      // dividend magnitude, shifts out MSB first, quotient bits shift in
  logic [din1_WIDTH-1:0] dvs;     // divisor magnitude
  logic [din1_WIDTH:0]   pr;      // partial remainder
  logic [CNT_W-1:0]      cnt;
  logic                  fin;     // all iterations done, next edge delivers
  logic                  zflag;   // divisor was zero
  logic                  sign_q;
  logic                  sign_r;

  // Magnitudes viewed as unsigned: the two's complement negation of MIN is exactly 2^(W-1).
  logic [din0_WIDTH-1:0] abs0;
  logic [din1_WIDTH-1:0] abs1;
  logic [din1_WIDTH:0]   trial;
  logic [din1_WIDTH+1:0] sub;
  logic                  take;

  assign abs0  = din0[din0_WIDTH-1] ? -din0 : din0;
  assign abs1  = din1[din1_WIDTH-1] ? -din1 : din1;
  assign trial = {pr[din1_WIDTH-1:0], dq[din0_WIDTH-1]};
  assign sub   = {1'b0, trial} - {2'b00, dvs};
  // A carry out of the shifted remainder means the trial value already exceeds the divisor.
  assign take  = pr[din1_WIDTH] | ~sub[din1_WIDTH+1];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = CALC;
      CALC:    if (zflag || fin) state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per edge, final sign fix-up into the result registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dq     <= '0;
      dvs    <= '0;
      pr     <= '0;
      cnt    <= '0;
      fin    <= 1'b0;
      zflag  <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quot   <= '0;
      rem    <= '0;
`ifdef SOBEL_SDIV_DBZ_FLAG_EN
      dbz    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dq     <= abs0;
            dvs    <= abs1;
            sign_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            sign_r <= din0[din0_WIDTH-1];
            zflag  <= (din1 == '0);
            pr     <= '0;
            cnt    <= '0;
            fin    <= 1'b0;
          end
        end
        CALC: begin
          if (zflag) begin
            // Negating the low bits of |din0| restores the raw din0 low bits.
            quot <= '0;
            rem  <= sign_r ? -dq[din1_WIDTH-1:0] : dq[din1_WIDTH-1:0];
`ifdef SOBEL_SDIV_DBZ_FLAG_EN
            dbz  <= 1'b1;
`endif
          end else if (fin) begin
            quot <= sign_q ? -dq : dq;
            rem  <= sign_r ? -pr[din1_WIDTH-1:0] : pr[din1_WIDTH-1:0];
`ifdef SOBEL_SDIV_DBZ_FLAG_EN
            dbz  <= 1'b0;
`endif
          end else begin
            pr  <= take ? sub[din1_WIDTH:0] : trial;
            dq  <= {dq[din0_WIDTH-2:0], take};
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            fin <= (cnt == CNT_LAST);
          end
        end
        DONE: begin
`ifdef SOBEL_SDIV_DBZ_FLAG_EN
          if (out_ready) dbz <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_rgb_green_outline_sdiv_21s_11s_seq.sv
// Bench for the sequential signed divider: directed sign/boundary tables, backpressure, reset abort, random pairs.
// Expected results are queued at issue and popped when out_valid is seen.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sobel_rgb_green_outline_sdiv_21s_11s_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] din0 = '0;
  logic [10:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [20:0] quot;
  logic [10:0] rem;
`ifdef SOBEL_SDIV_DBZ_FLAG_EN
  logic        dbz;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {logic [20:0] q; logic [10:0] r; logic z;} exp_t;
  typedef struct {logic [20:0] a; logic [10:0] b; logic [20:0] q; logic [10:0] r; int lat;} vec_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_rgb_green_outline_sdiv_21s_11s_seq dut (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
`ifdef SOBEL_SDIV_DBZ_FLAG_EN
    .dbz(dbz),
`endif
    .quot(quot), .rem(rem)
  );

  function automatic exp_t model(input logic [20:0] a, input logic [10:0] b);
    exp_t m;
    int ai, bi, qi, ri;
    ai = $signed(a);
    bi = $signed(b);
    if (bi == 0) begin
      m.q = '0; m.r = a[10:0]; m.z = 1'b1;
    end else begin
      qi = ai / bi; ri = ai % bi;
      m.q = qi[20:0]; m.r = ri[10:0]; m.z = 1'b0;
    end
    return m;
  endfunction

  // Hold the operands until accepted; t_acc is the cycle count right after the accept edge.
  task automatic issue(input logic [20:0] a, input logic [10:0] b, output int t_acc);
    logic done;
    done = 1'b0; t_acc = -1;
    din0 = a; din1 = b; in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (done) t_acc = cyc;
    else begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (quot !== 21'd0 || rem !== 11'd0) begin miscompares++; $display("FAIL reset_result: got %h/%h want 0/0", quot, rem); end
    rst = 1'b0;
  endtask

  task automatic test_signs();
    vec_t v[4];
    exp_t e;
    int t, lat;
    v[0] = '{a: 21'sd100,  b: 11'sd7,  q: 21'sd14,  r: 11'sd2,  lat: 22};
    v[1] = '{a: -21'sd100, b: 11'sd7,  q: -21'sd14, r: -11'sd2, lat: 22};
    v[2] = '{a: 21'sd100,  b: -11'sd7, q: -21'sd14, r: 11'sd2,  lat: 22};
    v[3] = '{a: -21'sd100, b: -11'sd7, q: 21'sd14,  r: -11'sd2, lat: 22};
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{q: v[i].q, r: v[i].r, z: 1'b0});
      issue(v[i].a, v[i].b, t);
      wait_out(lat);
      e = sb.pop_front();
      vectors++; if (lat !== v[i].lat) begin miscompares++; $display("FAIL sign_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      vectors++; if (quot !== e.q || rem !== e.r) begin miscompares++;
        $display("FAIL sign_result[%0d]: got %0d/%0d want %0d/%0d", i, $signed(quot), $signed(rem), $signed(e.q), $signed(e.r)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_boundary();
    vec_t v[9];
    exp_t e;
    int t, lat;
    v[0] = '{a: -21'sd1048576, b: -11'sd1,   q: -21'sd1048576, r: 11'sd0,    lat: 22};
    v[1] = '{a: 21'sd1048575,  b: -11'sd1024, q: -21'sd1023,   r: 11'sd1023, lat: 22};
    v[2] = '{a: -21'sd1048576, b: 11'sd1,    q: -21'sd1048576, r: 11'sd0,    lat: 22};
    v[3] = '{a: 21'sd1048575,  b: 11'sd1023, q: 21'sd1025,     r: 11'sd0,    lat: 22};
    v[4] = '{a: 21'sd0,        b: 11'sd5,    q: 21'sd0,        r: 11'sd0,    lat: 22};
    v[5] = '{a: 21'sd3,        b: -11'sd9,   q: 21'sd0,        r: 11'sd3,    lat: 22};
    v[6] = '{a: -21'sd3,       b: 11'sd9,    q: 21'sd0,        r: -11'sd3,   lat: 22};
    v[7] = '{a: 21'sd1234,     b: 11'sd0,    q: 21'sd0,        r: 11'h4D2,   lat: 1};
    v[8] = '{a: -21'sd5,       b: 11'sd0,    q: 21'sd0,        r: 11'h7FB,   lat: 1};
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{q: v[i].q, r: v[i].r, z: (v[i].b == 11'd0)});
      issue(v[i].a, v[i].b, t);
      wait_out(lat);
      e = sb.pop_front();
      vectors++; if (lat !== v[i].lat) begin miscompares++; $display("FAIL bound_latency[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      vectors++; if (quot !== e.q || rem !== e.r) begin miscompares++;
        $display("FAIL bound_result[%0d]: got %h/%h want %h/%h", i, quot, rem, e.q, e.r); end
`ifdef SOBEL_SDIV_DBZ_FLAG_EN
      vectors++; if (dbz !== e.z) begin miscompares++; $display("FAIL bound_dbz[%0d]: got %b want %b", i, dbz, e.z); end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int t, lat;
    out_ready = 1'b0;
    sb.push_back('{q: -21'sd55, r: 11'sd5, z: 1'b0});
    issue(21'sd500, -11'sd9, t);
    wait_out(lat);
    e = sb.pop_front();
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== e.q || rem !== e.r) begin miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b %0d/%0d want v=1 rdy=0 %0d/%0d",
                 k, out_valid, in_ready, $signed(quot), $signed(rem), $signed(e.q), $signed(e.r)); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_consume_rdy: got %b want 0", in_ready); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int t, t_rst, lat;
    sb.push_back(model(21'sd300, 11'sd3));
    issue(21'sd300, 11'sd3, t);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    t_rst = cyc;
    sb.delete();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || quot !== 21'd0 || rem !== 11'd0) begin miscompares++;
      $display("FAIL abort_state: got v=%b rdy=%b %h/%h want v=0 rdy=1 0/0", out_valid, in_ready, quot, rem); end
    sb.push_back('{q: 21'sd10, r: 11'sd0, z: 1'b0});
    issue(21'sd50, 11'sd5, t);
    vectors++; if (t !== t_rst + 1) begin miscompares++; $display("FAIL abort_first_accept: got %0d want %0d", t, t_rst + 1); end
    wait_out(lat);
    e = sb.pop_front();
    vectors++; if (lat !== 22) begin miscompares++; $display("FAIL abort_latency: got %0d want 22", lat); end
    vectors++; if (quot !== e.q || rem !== e.r) begin miscompares++;
      $display("FAIL abort_result: got %0d/%0d want %0d/%0d", $signed(quot), $signed(rem), $signed(e.q), $signed(e.r)); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int t1, t2, lat;
    sb.push_back(model(21'sd77777, -11'sd13));
    issue(21'sd77777, -11'sd13, t1);
    sb.push_back(model(-21'sd4096, 11'sd3));
    fork
      issue(-21'sd4096, 11'sd3, t2);
      begin
        wait_out(lat);
        e = sb.pop_front();
        vectors++; if (quot !== e.q || rem !== e.r) begin miscompares++;
          $display("FAIL b2b_first: got %0d/%0d want %0d/%0d", $signed(quot), $signed(rem), $signed(e.q), $signed(e.r)); end
      end
    join
    vectors++; if (t2 - t1 !== 24) begin miscompares++; $display("FAIL b2b_interval: got %0d want 24", t2 - t1); end
    wait_out(lat);
    e = sb.pop_front();
    vectors++; if (quot !== e.q || rem !== e.r) begin miscompares++;
      $display("FAIL b2b_second: got %0d/%0d want %0d/%0d", $signed(quot), $signed(rem), $signed(e.q), $signed(e.r)); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    exp_t e;
    logic [20:0] a;
    logic [10:0] b;
    int t, lat;
    for (int i = 0; i < 1500; i++) begin
      a = 21'($urandom);
      if ($urandom_range(0, 15) == 0) a = 21'h100000;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 11'($urandom_range(1, 15));
        2:       b = '1;
        3:       b = 11'h400;
        default: b = 11'($urandom);
      endcase
      sb.push_back(model(a, b));
      issue(a, b, t);
      wait_out(lat);
      e = sb.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || lat !== ((b == 11'd0) ? 1 : 22) || quot !== e.q || rem !== e.r) begin miscompares++;
        $display("FAIL rand[%0d]: %0d/%0d got v=%b lat=%0d %0d/%0d want %0d/%0d", i, $signed(a), $signed(b),
                 out_valid, lat, $signed(quot), $signed(rem), $signed(e.q), $signed(e.r)); end
`ifdef SOBEL_SDIV_DBZ_FLAG_EN
      vectors++; if (dbz !== e.z) begin miscompares++; $display("FAIL rand_dbz[%0d]: got %b want %b", i, dbz, e.z); end
`endif
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_signs();
    test_boundary();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
